// File: rtl/bloke2_digest_collector.sv
// rtl/bloke2_digest_collector.sv - serial digest byte collector with handshake and compare
//
// Purpose: assembles the bloke2 core's serial digest bytes into a parallel
// register, holds it under a valid/ready handshake, compares it against a
// reference digest and flags short, long and overrun streams.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   hash_byte       digest byte from the hash core
//   hash_valid      hash_byte is valid this cycle
//   hash_end        hash_byte is the final digest byte (only with hash_valid)
//   expected        reference digest, byte 0 in [7:0]
//   digest          collected digest, first received byte in [7:0]
//   digest_len      number of bytes stored
//   digest_valid    digest and flags are presented
//   digest_ready    consumer accepts the presented digest
//   match           digest equals expected and the stream was well formed
//   err_short       stream ended before DIGEST_BYTES bytes
//   err_long        stream carried more than DIGEST_BYTES bytes
//   overrun         sticky: a byte was dropped while a digest was held
module bloke2_digest_collector #(
  parameter int DIGEST_BYTES = 64,
  parameter int CNT_W        = $clog2(DIGEST_BYTES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                hash_byte,
  input  logic                      hash_valid,
  input  logic                      hash_end,
  input  logic [DIGEST_BYTES*8-1:0] expected,
  output logic [DIGEST_BYTES*8-1:0] digest,
  output logic [CNT_W-1:0]          digest_len,
  output logic                      digest_valid,
  input  logic                      digest_ready,
  output logic                      match,
  output logic                      err_short,
  output logic                      err_long,
  output logic                      overrun
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DIGEST_BYTES);

  state_e                    state_q, state_d;
  logic [DIGEST_BYTES*8-1:0] digest_q, digest_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      err_short_q, err_short_d;
  logic                      err_long_q, err_long_d;
  logic                      overrun_q, overrun_d;
  logic                      accept;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= COLLECT;
      digest_q    <= '0;
      cnt_q       <= '0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digest_q    <= digest_d;
      cnt_q       <= cnt_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digest_d    = digest_q;
    cnt_d       = cnt_q;
    err_short_d = err_short_q;
    err_long_d  = err_long_q;
    overrun_d   = overrun_q;
    accept      = 1'b0;

    case (state_q)
      COLLECT: accept = 1'b1;
      HOLD: begin
        if (digest_ready) begin
          // Clear first, then let the collect step below write into the
          // cleared register so a same-cycle byte becomes byte 0.
          state_d     = COLLECT;
          digest_d    = '0;
          cnt_d       = '0;
          err_short_d = 1'b0;
          err_long_d  = 1'b0;
          accept      = 1'b1;
        end else if (hash_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase

    if (accept && hash_valid) begin
      if (cnt_d < FULL) begin
        for (int i = 0; i < DIGEST_BYTES; i++) begin
          if (cnt_d == CNT_W'(i)) digest_d[i*8 +: 8] = hash_byte;
        end
        cnt_d = cnt_d + CNT_W'(1);
      end else begin
        err_long_d = 1'b1;
      end
      if (hash_end) begin
        state_d     = HOLD;
        err_short_d = (cnt_d < FULL);
      end
    end
  end

  assign digest       = digest_q;
  assign digest_len   = cnt_q;
  assign digest_valid = (state_q == HOLD);
  assign err_short    = err_short_q;
  assign err_long     = err_long_q;
  assign overrun      = overrun_q;
  assign match        = digest_valid && !err_short_q && !err_long_q && (digest_q == expected);

endmodule

// File: tb/tb_bloke2_digest_collector.sv
// tb/tb_bloke2_digest_collector.sv - directed bench for bloke2_digest_collector
module tb_bloke2_digest_collector;

  localparam int DB = 64;
  localparam int CW = $clog2(DB + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      hash_byte = 8'h00;
  logic            hash_valid = 1'b0;
  logic            hash_end = 1'b0;
  logic [DB*8-1:0] expected = '0;
  logic [DB*8-1:0] digest;
  logic [CW-1:0]   digest_len;
  logic            digest_valid;
  logic            digest_ready = 1'b0;
  logic            match;
  logic            err_short;
  logic            err_long;
  logic            overrun;

  int n_assert = 0;
  int n_fail   = 0;

  logic [DB*8-1:0] ref_d;

  bloke2_digest_collector #(.DIGEST_BYTES(DB)) dut (
    .clk          (clk),
    .rst          (rst),
    .hash_byte    (hash_byte),
    .hash_valid   (hash_valid),
    .hash_end     (hash_end),
    .expected     (expected),
    .digest       (digest),
    .digest_len   (digest_len),
    .digest_valid (digest_valid),
    .digest_ready (digest_ready),
    .match        (match),
    .err_short    (err_short),
    .err_long     (err_long),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model(input int n, input int base, input int inc);
    logic [511:0] m;
    m = '0;
    for (int i = 0; i < n && i < 64; i++) m[i*8 +: 8] = 8'(base + i * inc);
    return m;
  endfunction

  task automatic send(input int n, input int base, input int inc, input bit do_end, input bit chk_mid);
    for (int i = 0; i < n; i++) begin
      hash_valid = 1'b1;
      hash_byte  = 8'(base + i * inc);
      hash_end   = do_end && (i == n - 1);
      tick();
      if (chk_mid && i < n - 1) chk("dv_mid", digest_valid, 0);
    end
    hash_valid = 1'b0;
    hash_end   = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rst_valid", digest_valid, 0);
    chk("rst_len", digest_len, 0);
    chk("rst_digest", digest, 0);
    chk("rst_short", err_short, 0);
    chk("rst_long", err_long, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_match", match, 0);

    // Full 64-byte digest 0x00..0x3F, consumer always ready
    ref_d        = model(64, 8'h00, 1);
    expected     = ref_d;
    digest_ready = 1'b1;
    send(64, 8'h00, 1, 1'b1, 1'b1);
    chk("t1_valid", digest_valid, 1);
    chk("t1_byte0", digest[7:0], 8'h00);
    chk("t1_byte63", digest[511:504], 8'h3F);
    chk("t1_digest", digest, ref_d);
    chk("t1_len", digest_len, 64);
    chk("t1_match", match, 1);
    chk("t1_short", err_short, 0);
    chk("t1_long", err_long, 0);
    tick();
    chk("t1_one_cycle", digest_valid, 0);
    chk("t1_match_off", match, 0);

    // Short stream: 32 x 0xA5
    digest_ready = 1'b0;
    ref_d        = model(32, 8'hA5, 0);
    expected     = ref_d;
    send(32, 8'hA5, 0, 1'b1, 1'b0);
    chk("t2_valid", digest_valid, 1);
    chk("t2_len", digest_len, 32);
    chk("t2_short", err_short, 1);
    chk("t2_upper", digest[511:256], 0);
    chk("t2_digest", digest, ref_d);
    chk("t2_match", match, 0);
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    chk("t2_released", digest_valid, 0);
    chk("t2_len_clr", digest_len, 0);

    // Long stream: 70 bytes 0x01..0x46
    ref_d    = model(64, 8'h01, 1);
    expected = ref_d;
    send(70, 8'h01, 1, 1'b1, 1'b0);
    chk("t3_valid", digest_valid, 1);
    chk("t3_long", err_long, 1);
    chk("t3_short", err_short, 0);
    chk("t3_len", digest_len, 64);
    chk("t3_byte63", digest[511:504], 8'h40);
    chk("t3_digest", digest, ref_d);
    chk("t3_match", match, 0);
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    chk("t3_long_clr", err_long, 0);

    // Held digest with bytes arriving and no handshake
    ref_d    = model(64, 8'h05, 3);
    expected = ref_d;
    send(64, 8'h05, 3, 1'b1, 1'b0);
    chk("t4_overrun_pre", overrun, 0);
    for (int c = 0; c < 10; c++) begin
      hash_valid = (c == 2 || c == 5 || c == 8);
      hash_byte  = 8'hEE;
      hash_end   = (c == 8);
      tick();
    end
    hash_valid = 1'b0;
    hash_end   = 1'b0;
    chk("t4_valid", digest_valid, 1);
    chk("t4_digest", digest, ref_d);
    chk("t4_len", digest_len, 64);
    chk("t4_overrun", overrun, 1);
    chk("t4_match", match, 1);
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    chk("t4_released", digest_valid, 0);
    chk("t4_sticky", overrun, 1);

    // Handshake with same-cycle byte 0x7E
    send(64, 8'h10, 1, 1'b1, 1'b0);
    chk("t5_hold", digest_valid, 1);
    digest_ready = 1'b1;
    hash_valid   = 1'b1;
    hash_byte    = 8'h7E;
    tick();
    digest_ready = 1'b0;
    hash_valid   = 1'b0;
    chk("t5_valid", digest_valid, 0);
    chk("t5_digest", digest, 512'h7E);
    chk("t5_len", digest_len, 1);
    chk("t5_sticky", overrun, 1);
    send(1, 8'h11, 0, 1'b1, 1'b0);
    chk("t5b_len", digest_len, 2);
    chk("t5b_short", err_short, 1);
    // Handshake with same-cycle final byte: straight back to HOLD
    digest_ready = 1'b1;
    hash_valid   = 1'b1;
    hash_end     = 1'b1;
    hash_byte    = 8'h22;
    tick();
    hash_valid   = 1'b0;
    hash_end     = 1'b0;
    digest_ready = 1'b0;
    chk("t5c_valid", digest_valid, 1);
    chk("t5c_len", digest_len, 1);
    chk("t5c_digest", digest, 512'h22);
    chk("t5c_short", err_short, 1);
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    chk("t5c_released", digest_valid, 0);

    // Reset mid-stream, then a clean full stream
    send(20, 8'hC0, 1, 1'b0, 1'b0);
    hash_end = 1'b1;
    tick();
    hash_end = 1'b0;
    chk("t6_end_novalid", digest_valid, 0);
    chk("t6_partial_len", digest_len, 20);
    rst        = 1'b0;
    hash_valid = 1'b1;
    hash_byte  = 8'h99;
    tick();
    rst        = 1'b1;
    hash_valid = 1'b0;
    chk("t6_rst_digest", digest, 0);
    chk("t6_rst_len", digest_len, 0);
    chk("t6_rst_valid", digest_valid, 0);
    chk("t6_rst_overrun", overrun, 0);
    chk("t6_rst_short", err_short, 0);
    chk("t6_rst_long", err_long, 0);
    ref_d        = model(64, 8'h40, 1);
    expected     = ref_d;
    digest_ready = 1'b1;
    send(64, 8'h40, 1, 1'b1, 1'b0);
    chk("t6_valid", digest_valid, 1);
    chk("t6_digest", digest, ref_d);
    chk("t6_len", digest_len, 64);
    chk("t6_match", match, 1);
    chk("t6_overrun", overrun, 0);
    tick();
    chk("t6_released", digest_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
